// File: rtl/decode_pkg.sv
// decode_pkg: constants and the instruction decoder shared by the decode/issue
// stage and the execute stage.
//   - OP_* : 6-bit uop encodings {class[2:0], funct3} consumed by execute
//   - OPC_*: RV32I major opcodes recognised by this front end
//   - decode_fn: pure combinational decode of one instruction word
package decode_pkg;

  localparam int W_AA_INSTR = 32;
  localparam int W_PD_UOPS  = 6;
  localparam int W_PD_DATA  = 32;
  localparam int W_PD_RADDR = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] CLS_R = 3'b000;
  localparam logic [2:0] CLS_I = 3'b010;
  localparam logic [2:0] CLS_B = 3'b011;

  localparam logic [5:0] OP_SUB   = 6'b001_000;
  localparam logic [5:0] OP_SRA   = 6'b001_101;
  localparam logic [5:0] OP_SRAI  = 6'b011_010;
  localparam logic [5:0] OP_AUIPC = 6'b100_000;
  localparam logic [5:0] OP_JAL   = 6'b100_001;
  localparam logic [5:0] OP_JALR  = 6'b100_010;
  localparam logic [5:0] OP_NOP   = 6'b111_111;

  typedef enum logic [1:0] {IMM_NONE, IMM_I, IMM_U, IMM_B} imm_kind_e;

  typedef struct packed {
    logic [5:0] uops;
    logic       use_rs;
    logic       use_rt;
    logic       writes_rd;
    logic       illegal;
    imm_kind_e  imm_kind;
  } dec_t;

  // Anything not explicitly recognised stays an illegal NOP with no operands.
  function automatic dec_t decode_fn(input logic [31:0] instr);
    dec_t       d;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = instr[14:12];
    f7 = instr[31:25];
    d  = '{uops: OP_NOP, use_rs: 1'b0, use_rt: 1'b0, writes_rd: 1'b0,
           illegal: 1'b1, imm_kind: IMM_NONE};
    case (instr[6:0])
      OPC_OP: begin
        if (f7 == F7_BASE) begin
          d = '{uops: {CLS_R, f3}, use_rs: 1'b1, use_rt: 1'b1, writes_rd: 1'b1,
                illegal: 1'b0, imm_kind: IMM_NONE};
        end else if ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))) begin
          d = '{uops: (f3 == 3'b000) ? OP_SUB : OP_SRA, use_rs: 1'b1, use_rt: 1'b1,
                writes_rd: 1'b1, illegal: 1'b0, imm_kind: IMM_NONE};
        end else begin
          d.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        // Shift-immediates carry funct7 in the immediate field and must be checked.
        if ((f3 == 3'b101) && (f7 == F7_ALT)) begin
          d = '{uops: OP_SRAI, use_rs: 1'b1, use_rt: 1'b0, writes_rd: 1'b1,
                illegal: 1'b0, imm_kind: IMM_I};
        end else if (((f3 == 3'b001) || (f3 == 3'b101)) && (f7 != F7_BASE)) begin
          d.illegal = 1'b1;
        end else begin
          d = '{uops: {CLS_I, f3}, use_rs: 1'b1, use_rt: 1'b0, writes_rd: 1'b1,
                illegal: 1'b0, imm_kind: IMM_I};
        end
      end
      OPC_BRANCH: begin
        // funct3 010/011 are not RV32I branches.
        if ((f3 == 3'b010) || (f3 == 3'b011)) begin
          d.illegal = 1'b1;
        end else begin
          d = '{uops: {CLS_B, f3}, use_rs: 1'b1, use_rt: 1'b1, writes_rd: 1'b0,
                illegal: 1'b0, imm_kind: IMM_B};
        end
      end
      OPC_AUIPC: begin
        d = '{uops: OP_AUIPC, use_rs: 1'b0, use_rt: 1'b0, writes_rd: 1'b1,
              illegal: 1'b0, imm_kind: IMM_U};
      end
      OPC_JAL: begin
        d = '{uops: OP_JAL, use_rs: 1'b0, use_rt: 1'b0, writes_rd: 1'b1,
              illegal: 1'b0, imm_kind: IMM_U};
      end
      OPC_JALR: begin
        if (f3 == 3'b000) begin
          d = '{uops: OP_JALR, use_rs: 1'b1, use_rt: 1'b0, writes_rd: 1'b1,
                illegal: 1'b0, imm_kind: IMM_I};
        end else begin
          d.illegal = 1'b1;
        end
      end
      default: begin
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 32-entry register file, two combinational read ports, one
// synchronous write port.
//   clk, rst           : clock, synchronous active-high reset (clears all entries)
//   ra_addr / ra_data  : read port A
//   rb_addr / rb_data  : read port B
//   we, waddr, wdata   : write port; the write value is also bypassed to reads
// x0 always reads zero and ignores writes.
module regfile_2r1w
  import decode_pkg::*;
#(
  parameter int W_DATA = W_PD_DATA,
  parameter int W_ADDR = W_PD_RADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_ADDR-1:0] ra_addr,
  output logic [W_DATA-1:0] ra_data,
  input  logic [W_ADDR-1:0] rb_addr,
  output logic [W_DATA-1:0] rb_data,
  input  logic              we,
  input  logic [W_ADDR-1:0] waddr,
  input  logic [W_DATA-1:0] wdata
);

  localparam int NREG = 2 ** W_ADDR;

  logic [W_DATA-1:0] mem_r [NREG];

  // Storage update: clear on reset, otherwise write any register but x0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read ports with same-cycle writeback bypass.
  always_comb begin
    ra_data = '0;
    rb_data = '0;
    if (ra_addr == '0) begin
      ra_data = '0;
    end else if (we && (waddr == ra_addr)) begin
      ra_data = wdata;
    end else begin
      ra_data = mem_r[ra_addr];
    end
    if (rb_addr == '0) begin
      rb_data = '0;
    end else if (we && (waddr == rb_addr)) begin
      rb_data = wdata;
    end else begin
      rb_data = mem_r[rb_addr];
    end
  end

endmodule

// File: rtl/decode_issue.sv
// decode_issue: RV32I decode/issue stage in front of the execute ALU.
//   clk, rst               : clock, synchronous active-high reset
//   DFI_AA_pc/PD_instr     : offered instruction, DFI_instr_valid / DFO_instr_ready handshake
//   DFI_stall              : freeze the output register
//   DFI_flush              : kill the instruction in the output register
//   DFI_wb_en/addr/data    : writeback into the register file, clears scoreboard bit
//   DFO_*                  : registered uop, operands, immediate, pc, rd, rd_we,
//                            valid and illegal, one cycle after acceptance
module decode_issue
  import decode_pkg::*;
#(
  parameter int W_AA_INSTR = decode_pkg::W_AA_INSTR,
  parameter int W_PD_UOPS  = decode_pkg::W_PD_UOPS,
  parameter int W_PD_DATA  = decode_pkg::W_PD_DATA,
  parameter int W_PD_RADDR = decode_pkg::W_PD_RADDR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W_AA_INSTR-1:0] DFI_AA_pc,
  input  logic [31:0]           DFI_PD_instr,
  input  logic                  DFI_instr_valid,
  output logic                  DFO_instr_ready,
  input  logic                  DFI_stall,
  input  logic                  DFI_flush,
  input  logic                  DFI_wb_en,
  input  logic [W_PD_RADDR-1:0] DFI_wb_addr,
  input  logic [W_PD_DATA-1:0]  DFI_wb_data,
  output logic [W_PD_UOPS-1:0]  DFO_PD_uops,
  output logic [W_PD_DATA-1:0]  DFO_PD_rs,
  output logic [W_PD_DATA-1:0]  DFO_PD_rt,
  output logic [W_PD_DATA-1:0]  DFO_PD_imm,
  output logic [W_AA_INSTR-1:0] DFO_AA_pc,
  output logic [W_PD_RADDR-1:0] DFO_PD_rd,
  output logic                  DFO_rd_we,
  output logic                  DFO_valid,
  output logic                  DFO_illegal
);

  localparam int NREG = 2 ** W_PD_RADDR;
  localparam logic [NREG-1:0] ONE_HOT_0 = {{(NREG-1){1'b0}}, 1'b1};

  dec_t                  dec_s;
  logic [W_PD_RADDR-1:0] rs_idx_s, rt_idx_s, rd_idx_s;
  logic [W_PD_DATA-1:0]  rf_rs_s, rf_rt_s, imm_s;
  logic                  rd_we_s, hazard_s, ready_s, xfer_s;
  logic [NREG-1:0]       pend_r, pend_nxt_s, set_mask_s, clr_mask_s;

  logic [W_PD_UOPS-1:0]  uops_r;
  logic [W_PD_DATA-1:0]  rs_r, rt_r, imm_r;
  logic [W_AA_INSTR-1:0] pc_r;
  logic [W_PD_RADDR-1:0] rd_r;
  logic                  rd_we_r, valid_r, illegal_r;

  assign rs_idx_s = DFI_PD_instr[19:15];
  assign rt_idx_s = DFI_PD_instr[24:20];
  assign rd_idx_s = DFI_PD_instr[11:7];

  regfile_2r1w #(.W_DATA(W_PD_DATA), .W_ADDR(W_PD_RADDR)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (rs_idx_s),
    .ra_data (rf_rs_s),
    .rb_addr (rt_idx_s),
    .rb_data (rf_rt_s),
    .we      (DFI_wb_en),
    .waddr   (DFI_wb_addr),
    .wdata   (DFI_wb_data)
  );

  // Decode, immediate extraction, hazard detection and handshake.
  always_comb begin
    dec_s   = decode_fn(DFI_PD_instr);
    rd_we_s = dec_s.writes_rd && (rd_idx_s != '0);
    imm_s   = '0;
    case (dec_s.imm_kind)
      IMM_I:   imm_s[11:0] = DFI_PD_instr[31:20];
      IMM_U:   imm_s[19:0] = DFI_PD_instr[31:12];
      IMM_B:   imm_s[12:0] = {DFI_PD_instr[31], DFI_PD_instr[7], DFI_PD_instr[30:25],
                              DFI_PD_instr[11:8], 1'b0};
      default: imm_s = '0;
    endcase
    // A pending source is fine if its value arrives through the bypass this cycle.
    hazard_s = (dec_s.use_rs && pend_r[rs_idx_s] && !(DFI_wb_en && (DFI_wb_addr == rs_idx_s)))
            || (dec_s.use_rt && pend_r[rt_idx_s] && !(DFI_wb_en && (DFI_wb_addr == rt_idx_s)));
    ready_s  = !rst && !DFI_stall && !hazard_s;
    xfer_s   = DFI_instr_valid && ready_s;
  end

  // Scoreboard next state: clears from writeback and flush, then set wins.
  always_comb begin
    clr_mask_s = (DFI_wb_en ? (ONE_HOT_0 << DFI_wb_addr) : '0)
               | ((DFI_flush && valid_r && rd_we_r) ? (ONE_HOT_0 << rd_r) : '0);
    set_mask_s = (xfer_s && !DFI_flush && rd_we_s) ? (ONE_HOT_0 << rd_idx_s) : '0;
    pend_nxt_s = ((pend_r & ~clr_mask_s) | set_mask_s) & ~ONE_HOT_0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r <= '0;
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

  // Output register: reset > flush > stall > transfer > bubble.
  always_ff @(posedge clk) begin
    if (rst || DFI_flush || (!DFI_stall && !xfer_s)) begin
      uops_r    <= OP_NOP;
      rs_r      <= '0;
      rt_r      <= '0;
      imm_r     <= '0;
      pc_r      <= '0;
      rd_r      <= '0;
      rd_we_r   <= 1'b0;
      valid_r   <= 1'b0;
      illegal_r <= 1'b0;
    end else if (DFI_stall) begin
      uops_r    <= uops_r;
      rs_r      <= rs_r;
      rt_r      <= rt_r;
      imm_r     <= imm_r;
      pc_r      <= pc_r;
      rd_r      <= rd_r;
      rd_we_r   <= rd_we_r;
      valid_r   <= valid_r;
      illegal_r <= illegal_r;
    end else begin
      uops_r    <= dec_s.uops;
      rs_r      <= dec_s.use_rs ? rf_rs_s : '0;
      rt_r      <= dec_s.use_rt ? rf_rt_s : '0;
      imm_r     <= imm_s;
      pc_r      <= DFI_AA_pc;
      rd_r      <= dec_s.writes_rd ? rd_idx_s : '0;
      rd_we_r   <= rd_we_s;
      valid_r   <= 1'b1;
      illegal_r <= dec_s.illegal;
    end
  end

  assign DFO_instr_ready = ready_s;
  assign DFO_PD_uops     = uops_r;
  assign DFO_PD_rs       = rs_r;
  assign DFO_PD_rt       = rt_r;
  assign DFO_PD_imm      = imm_r;
  assign DFO_AA_pc       = pc_r;
  assign DFO_PD_rd       = rd_r;
  assign DFO_rd_we       = rd_we_r;
  assign DFO_valid       = valid_r;
  assign DFO_illegal     = illegal_r;

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed self-checking bench for decode_issue.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, instr;
  logic        valid, ready, stall, flush, wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [5:0]  o_uops;
  logic [31:0] o_rs, o_rt, o_imm, o_pc;
  logic [4:0]  o_rd;
  logic        o_rd_we, o_valid, o_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  decode_issue dut (
    .clk             (clk),
    .rst             (rst),
    .DFI_AA_pc       (pc),
    .DFI_PD_instr    (instr),
    .DFI_instr_valid (valid),
    .DFO_instr_ready (ready),
    .DFI_stall       (stall),
    .DFI_flush       (flush),
    .DFI_wb_en       (wb_en),
    .DFI_wb_addr     (wb_addr),
    .DFI_wb_data     (wb_data),
    .DFO_PD_uops     (o_uops),
    .DFO_PD_rs       (o_rs),
    .DFO_PD_rt       (o_rt),
    .DFO_PD_imm      (o_imm),
    .DFO_AA_pc       (o_pc),
    .DFO_PD_rd       (o_rd),
    .DFO_rd_we       (o_rd_we),
    .DFO_valid       (o_valid),
    .DFO_illegal     (o_illegal)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [5:0] uops, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [31:0] imm, input logic [31:0] opc,
                           input logic [4:0] rd, input logic we, input logic v, input logic ill);
    check({tag, ".uops"},    64'(o_uops),    64'(uops));
    check({tag, ".rs"},      64'(o_rs),      64'(rs));
    check({tag, ".rt"},      64'(o_rt),      64'(rt));
    check({tag, ".imm"},     64'(o_imm),     64'(imm));
    check({tag, ".pc"},      64'(o_pc),      64'(opc));
    check({tag, ".rd"},      64'(o_rd),      64'(rd));
    check({tag, ".rd_we"},   64'(o_rd_we),   64'(we));
    check({tag, ".valid"},   64'(o_valid),   64'(v));
    check({tag, ".illegal"}, 64'(o_illegal), 64'(ill));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pc = 32'h0; instr = 32'h0; valid = 1'b0; stall = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    tick(); tick();

    // Reset state, instruction offered while in reset
    valid = 1'b1; pc = 32'h100; instr = 32'h00500093;  // ADDI x1,x0,5
    #1 check("rst_ready", 64'(ready), 64'd0);
    check_out("rst", 6'h3F, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1 check("addi_ready", 64'(ready), 64'd1);
    tick();
    check_out("addi_x1", 6'b010_000, 32'd0, 32'd0, 32'd5, 32'h100, 5'd1, 1'b1, 1'b1, 1'b0);

    // ADD x2,x1,x1 waits on x1, issues in the writeback cycle through the bypass
    pc = 32'h104; instr = 32'h00108133;
    #1 check("add_raw_ready", 64'(ready), 64'd0);
    tick();
    check("add_wait_valid", 64'(o_valid), 64'd0);
    check("add_wait_uops", 64'(o_uops), 64'h3F);
    check("add_wait_ready", 64'(ready), 64'd0);
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd5;
    #1 check("add_wb_ready", 64'(ready), 64'd1);
    tick();
    wb_en = 1'b0;
    check_out("add_bypass", 6'b000_000, 32'd5, 32'd5, 32'd0, 32'h104, 5'd2, 1'b1, 1'b1, 1'b0);

    // BEQ x0,x0,+8 (rd field = 8) must not mark x8 pending
    pc = 32'h108; instr = 32'h00000463;
    tick();
    check_out("beq", 6'b011_000, 32'd0, 32'd0, 32'd8, 32'h108, 5'd0, 1'b0, 1'b1, 1'b0);
    pc = 32'h10C; instr = 32'h00140293;  // ADDI x5,x8,1
    #1 check("beq_no_pend", 64'(ready), 64'd1);
    tick();

    // LUI x1 is unsupported: illegal NOP, x1 must not become pending
    pc = 32'h110; instr = 32'h123450b7;
    tick();
    check_out("lui", 6'h3F, 32'd0, 32'd0, 32'd0, 32'h110, 5'd0, 1'b0, 1'b1, 1'b1);
    pc = 32'h114; instr = 32'h00008313;  // ADDI x6,x1,0
    #1 check("lui_no_pend", 64'(ready), 64'd1);
    tick();
    check_out("addi_x6", 6'b010_000, 32'd5, 32'd0, 32'd0, 32'h114, 5'd6, 1'b1, 1'b1, 1'b0);

    // AUIPC x11,0x12345
    pc = 32'h118; instr = 32'h12345597;
    tick();
    check_out("auipc", 6'b100_000, 32'd0, 32'd0, 32'h12345, 32'h118, 5'd11, 1'b1, 1'b1, 1'b0);

    // ADDI x4 then flush; the ADDI x7 offered during the flush is discarded
    pc = 32'h11C; instr = 32'h00700213;
    tick();
    check("x4_rd", 64'(o_rd), 64'd4);
    flush = 1'b1; pc = 32'h120; instr = 32'h00100393;
    tick();
    flush = 1'b0;
    check_out("flush", 6'h3F, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    pc = 32'h124; instr = 32'h00720433;  // ADD x8,x4,x7
    #1 check("post_flush_ready", 64'(ready), 64'd1);
    tick();
    check_out("add_x8", 6'b000_000, 32'd0, 32'd0, 32'd0, 32'h124, 5'd8, 1'b1, 1'b1, 1'b0);

    // Stall for three cycles with an instruction offered: outputs frozen
    stall = 1'b1; pc = 32'h128; instr = 32'h00300493;  // ADDI x9,x0,3
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_ready", 64'(ready), 64'd0);
      tick();
      check_out("stall", 6'b000_000, 32'd0, 32'd0, 32'd0, 32'h124, 5'd8, 1'b1, 1'b1, 1'b0);
    end

    // Reset during the stall wipes outputs, regfile and scoreboard
    rst = 1'b1;
    tick();
    check_out("rst_mid", 6'h3F, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("rst_mid_ready", 64'(ready), 64'd0);
    rst = 1'b0; stall = 1'b0; pc = 32'h12C; instr = 32'h00208533;  // ADD x10,x1,x2
    #1 check("post_rst_ready", 64'(ready), 64'd1);
    tick();
    check_out("post_rst", 6'b000_000, 32'd0, 32'd0, 32'd0, 32'h12C, 5'd10, 1'b1, 1'b1, 1'b0);

    valid = 1'b0;
    tick();
    check("idle_valid", 64'(o_valid), 64'd0);
    check("idle_uops", 64'(o_uops), 64'h3F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
